// File: rtl/ddr_dmaster_st_pkg.sv
// Shared definitions for the debug-master stream channel arbiter.
package ddr_dmaster_st_pkg;

    // Arbiter FSM encoding, kept as plain constants for legacy netlists.
    localparam logic ARB_IDLE   = 1'b0;
    localparam logic ARB_LOCKED = 1'b1;

    // Ceiling log2 used to size grant/pointer registers; never below 1 bit.
    function automatic int unsigned dm_clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/ddr_dmaster_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr_i, wrapping.
module ddr_dmaster_rr_pick
    import ddr_dmaster_st_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = dm_clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int unsigned      sum;
    logic [IDX_W-1:0] cand;

    // Walk N positions upward from the pointer; the first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= N) begin
                sum = sum - N;
            end
            cand = IDX_W'(sum);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ddr_dmaster_st_channel_arbiter.sv
// Packet-atomic round-robin arbiter feeding the byte-to-packet adapter.
// Each beat carries the granted requester index on out_channel; one
// registered output stage, one arbitration bubble per packet.
module ddr_dmaster_st_channel_arbiter
    import ddr_dmaster_st_pkg::*;
#(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        req_valid,
    output logic [NUM_IN-1:0]        req_ready,
    input  logic [NUM_IN*DATA_W-1:0] req_data,
    input  logic [NUM_IN-1:0]        req_startofpacket,
    input  logic [NUM_IN-1:0]        req_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     sop_error
);

    localparam int unsigned GW       = dm_clog2(NUM_IN);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_IN - 1);

    logic                 state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 first_q, first_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [CHANNEL_W-1:0] out_channel_q, out_channel_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic                 sop_error_q, sop_error_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic                 sel_valid, sel_sop, sel_eop;
    logic [DATA_W-1:0]    sel_data;
    logic                 stage_free, in_locked, beat_acc;

    ddr_dmaster_rr_pick #(
        .N     (NUM_IN),
        .IDX_W (GW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign stage_free = !out_valid_q || out_ready;
    assign in_locked  = (state_q == ARB_LOCKED);
    assign beat_acc   = in_locked && sel_valid && stage_free;

    // Select the currently granted requester's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
                sel_sop   = req_startofpacket[i];
                sel_eop   = req_endofpacket[i];
            end
        end
    end

    // Only the granted requester sees ready, and only while locked.
    always_comb begin
        req_ready = '0;
        if (in_locked) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (grant_q == GW'(i)) begin
                    req_ready[i] = stage_free;
                end
            end
        end
    end

    // Arbitration FSM plus output-stage and error-flag next state.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        first_d       = first_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        sop_error_d   = sop_error_q;

        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                grant_d = pick_idx;
                state_d = ARB_LOCKED;
                first_d = 1'b1;
            end
        end else if (beat_acc) begin
            first_d = 1'b0;
            if (sel_eop) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
            end
        end

        if (stage_free) begin
            out_valid_d = beat_acc;
            if (beat_acc) begin
                out_data_d    = sel_data;
                out_channel_d = CHANNEL_W'(grant_q);
                out_sop_d     = sel_sop;
                out_eop_d     = sel_eop;
            end
        end

        if (beat_acc && first_q && !sel_sop) begin
            sop_error_d = 1'b1;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            first_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            sop_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            first_q       <= first_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            sop_error_q   <= sop_error_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_channel_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign sop_error         = sop_error_q;

endmodule

// File: tb/tb_ddr_dmaster_st_channel_arbiter.sv
// Scoreboard bench for the packet-atomic round-robin stream arbiter.
module tb_ddr_dmaster_st_channel_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] ch;
        logic       sop;
        logic       eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [3:0]  req_startofpacket;
    logic [3:0]  req_endofpacket;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [7:0]  out_channel;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        sop_error;

    int          checks = 0;
    int          failures = 0;
    beat_t       src_q [4][$];
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [3:0]  gate = 4'hF;
    logic [3:0]  acc;

    ddr_dmaster_st_channel_arbiter #(
        .NUM_IN    (4),
        .DATA_W    (8),
        .CHANNEL_W (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_data          (req_data),
        .req_startofpacket (req_startofpacket),
        .req_endofpacket   (req_endofpacket),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .sop_error         (sop_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_push(input int i, input logic [7:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        src_q[i].push_back(b);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic [7:0] ch, input logic s, input logic e);
        exp_t x;
        x.data = d;
        x.ch   = ch;
        x.sop  = s;
        x.eop  = e;
        exp_q.push_back(x);
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_%s: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_%s: out_valid got 0 expected 1 within 50 cycles", name);
        end
    endtask

    // Source driver: retire handshaken beats, present the next head beat.
    initial begin
        req_valid         = '0;
        req_data          = '0;
        req_startofpacket = '0;
        req_endofpacket   = '0;
        forever begin
            @(negedge clk);
            acc = reset_n ? (req_valid & req_ready) : 4'h0;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
                if (src_q[i].size() != 0 && gate[i]) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*8 +: 8]    = src_q[i][0].data;
                    req_startofpacket[i]  = src_q[i][0].sop;
                    req_endofpacket[i]    = src_q[i][0].eop;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every transferred output beat is matched against the queue.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h ch %0d, expected no beat", out_data, out_channel);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(mon_e.data));
                check("beat_channel", 32'(out_channel), 32'(mon_e.ch));
                check("beat_sop", 32'(out_startofpacket), 32'(mon_e.sop));
                check("beat_eop", 32'(out_endofpacket), 32'(mon_e.eop));
            end
        end
    end

    initial begin
        logic [5:0] vpat;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        #23;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_channel", 32'(out_channel), 0);
        check("rst_out_sop", 32'(out_startofpacket), 0);
        check("rst_out_eop", 32'(out_endofpacket), 0);
        check("rst_sop_error", 32'(sop_error), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Fairness: all four valid with two 1-beat packets each, from rr_ptr=0.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                src_push(i, 8'(i), 1'b1, 1'b1);
                expect_beat(8'(i), 8'(i), 1'b1, 1'b1);
            end
        end
        drain("fair");

        // Requester 2 three-beat packet; out_valid on cycles 2..4.
        @(negedge clk);
        src_push(2, 8'h11, 1'b1, 1'b0);
        src_push(2, 8'h22, 1'b0, 1'b0);
        src_push(2, 8'h33, 1'b0, 1'b1);
        expect_beat(8'h11, 8'd2, 1'b1, 1'b0);
        expect_beat(8'h22, 8'd2, 1'b0, 1'b0);
        expect_beat(8'h33, 8'd2, 1'b0, 1'b1);
        @(posedge clk);
        vpat = 6'b011100;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("latency_valid_c%0d", c), 32'(out_valid), 32'(vpat[c]));
        end
        drain("req2");

        // rr_ptr is now 3: requester 3 beats requester 0.
        src_push(0, 8'hA0, 1'b1, 1'b1);
        src_push(3, 8'hA3, 1'b1, 1'b1);
        expect_beat(8'hA3, 8'd3, 1'b1, 1'b1);
        expect_beat(8'hA0, 8'd0, 1'b1, 1'b1);
        drain("rrptr");

        // No interleaving: requester 1 waits out requester 0's packet, incl. a valid gap.
        src_push(0, 8'hB0, 1'b1, 1'b0);
        src_push(0, 8'hB1, 1'b0, 1'b0);
        src_push(0, 8'hB2, 1'b0, 1'b0);
        src_push(0, 8'hB3, 1'b0, 1'b1);
        expect_beat(8'hB0, 8'd0, 1'b1, 1'b0);
        expect_beat(8'hB1, 8'd0, 1'b0, 1'b0);
        expect_beat(8'hB2, 8'd0, 1'b0, 1'b0);
        expect_beat(8'hB3, 8'd0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        src_push(1, 8'hC0, 1'b1, 1'b0);
        src_push(1, 8'hC1, 1'b0, 1'b1);
        expect_beat(8'hC0, 8'd1, 1'b1, 1'b0);
        expect_beat(8'hC1, 8'd1, 1'b0, 1'b1);
        gate[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("lock_gap_ready1", 32'(req_ready[1]), 0);
        end
        @(posedge clk);
        #2;
        gate[0] = 1'b1;
        for (int c = 0; c < 20 && src_q[0].size() != 0; c++) begin
            @(negedge clk);
            check("lock_ready1", 32'(req_ready[1]), 0);
        end
        drain("lock");

        // Backpressure: 5 stalled cycles on requester 2's first beat.
        src_push(2, 8'hD0, 1'b1, 1'b0);
        src_push(2, 8'hD1, 1'b0, 1'b0);
        src_push(2, 8'hD2, 1'b0, 1'b1);
        expect_beat(8'hD0, 8'd2, 1'b1, 1'b0);
        expect_beat(8'hD1, 8'd2, 1'b0, 1'b0);
        expect_beat(8'hD2, 8'd2, 1'b0, 1'b1);
        wait_out_valid("bp");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 32'h0D0);
            check("bp_channel", 32'(out_channel), 2);
            check("bp_ready2", 32'(req_ready[2]), 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("bp");

        // Missing SOP on requester 3: beat passes, sticky error raised.
        check("sop_err_before", 32'(sop_error), 0);
        src_push(3, 8'h5A, 1'b0, 1'b1);
        expect_beat(8'h5A, 8'd3, 1'b0, 1'b1);
        drain("soperr");
        check("sop_err_set", 32'(sop_error), 1);
        src_push(0, 8'h77, 1'b1, 1'b1);
        expect_beat(8'h77, 8'd0, 1'b1, 1'b1);
        drain("soperr2");
        check("sop_err_sticky", 32'(sop_error), 1);

        // Reset mid-packet while a stalled beat sits in the stage.
        out_ready = 1'b0;
        src_push(1, 8'hE0, 1'b1, 1'b0);
        src_push(1, 8'hE1, 1'b0, 1'b0);
        src_push(1, 8'hE2, 1'b0, 1'b1);
        wait_out_valid("rst");
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_channel", 32'(out_channel), 0);
        check("mid_rst_sop_error", 32'(sop_error), 0);
        check("mid_rst_req_ready", 32'(req_ready), 0);
        src_q[1].delete();
        src_push(0, 8'hF0, 1'b1, 1'b1);
        src_push(3, 8'hF3, 1'b1, 1'b1);
        expect_beat(8'hF0, 8'd0, 1'b1, 1'b1);
        expect_beat(8'hF3, 8'd3, 1'b1, 1'b1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
